vga_timing_gen: RTL and testbench

//  Parametrised VGA/raster timing generator: programmable H/V timing, sync polarity, pixel-fetch

---
 rtl/vga_timing_gen.sv | 196 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: shadowed H/V timing, sync polarity control,
// pixel-fetch latency compensation, built-in test patterns and a sticky
// underflow flag for late buffer data.
module vga_timing_gen #(
    parameter int HW        = 11,
    parameter int VW        = 10,
    parameter int CW        = 4,
    parameter int REQ_LAT   = 1,
    parameter int BAR_SHIFT = 6
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en_i,
    input  logic [HW-1:0]   h_total_i,
    input  logic [HW-1:0]   h_sync_i,
    input  logic [HW-1:0]   h_act_start_i,
    input  logic [HW-1:0]   h_act_end_i,
    input  logic [VW-1:0]   v_total_i,
    input  logic [VW-1:0]   v_sync_i,
    input  logic [VW-1:0]   v_act_start_i,
    input  logic [VW-1:0]   v_act_end_i,
    input  logic            hs_pol_i,
    input  logic            vs_pol_i,
    input  logic [1:0]      mode_i,
    input  logic [3*CW-1:0] solid_i,
    input  logic [3*CW-1:0] data_i,
    input  logic            data_valid_i,
    input  logic            underflow_clr_i,
    output logic            data_req_o,
    output logic [CW-1:0]   red_o,
    output logic [CW-1:0]   green_o,
    output logic [CW-1:0]   blue_o,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            de_o,
    output logic            frame_start_o,
    output logic            underflow_o
);

    localparam int unsigned LAT = REQ_LAT;

    typedef enum logic [1:0] {
        MODE_BUFFER  = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_SOLID   = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_t;

    // Per-pixel information travelling alongside the fetch latency.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        mode_t      mode;
        logic [2:0] bar;
        logic       chk;
    } stage_t;

    logic [HW-1:0]   h_tot, h_sync, h_as, h_ae;
    logic [VW-1:0]   v_tot, v_sync, v_as, v_ae;
    logic            hs_pol, vs_pol;
    mode_t           mode;
    logic [3*CW-1:0] solid;

    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            run;
    logic            h_wrap, v_wrap, frame_end;

    stage_t          s0;
    stage_t          pipe [LAT];
    stage_t          sl;

    logic [CW-1:0]   pix_r, pix_g, pix_b;
    logic            under;

    assign run       = resetn && en_i;
    // A total below 2 pins the counter at 0, so it wraps every cycle.
    assign h_wrap    = (h_tot < HW'(2)) || (h_cnt == h_tot - HW'(1));
    assign v_wrap    = (v_tot < VW'(2)) || (v_cnt == v_tot - VW'(1));
    assign frame_end = h_wrap && v_wrap;
    assign sl        = pipe[LAT-1];

    // Shadow timing/mode: track inputs while idle, otherwise reload only at the last pixel of a frame.
    always_ff @(posedge clk) begin
        if (!run || frame_end) begin
            h_tot  <= h_total_i;
            h_sync <= h_sync_i;
            h_as   <= h_act_start_i;
            h_ae   <= h_act_end_i;
            v_tot  <= v_total_i;
            v_sync <= v_sync_i;
            v_as   <= v_act_start_i;
            v_ae   <= v_act_end_i;
            hs_pol <= hs_pol_i;
            vs_pol <= vs_pol_i;
            mode   <= mode_t'(mode_i);
            solid  <= solid_i;
        end
    end

    // Raster position counters.
    always_ff @(posedge clk) begin
        if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Stage-0 decode of the current raster position.
    always_comb begin
        s0      = '0;
        s0.hs   = h_cnt < h_sync;
        s0.vs   = v_cnt < v_sync;
        s0.act  = (h_cnt >= h_as) && (h_cnt < h_ae) && (v_cnt >= v_as) && (v_cnt < v_ae);
        s0.fs   = (h_cnt == '0) && (v_cnt == '0);
        s0.mode = mode;
        s0.bar  = 3'((h_cnt - h_as) >> BAR_SHIFT);
        s0.chk  = 1'((h_cnt - h_as) >> BAR_SHIFT) ^ 1'((v_cnt - v_as) >> BAR_SHIFT);
    end

    assign data_req_o = s0.act && (mode == MODE_BUFFER) && run;

    // Delay line matching the buffer fetch latency; flushed whenever idle.
    always_ff @(posedge clk) begin
        if (!run) begin
            for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= s0;
            for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Colour selection at the stage where buffer data arrives.
    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        under = 1'b0;
        if (sl.act) begin
            case (sl.mode)
                MODE_BUFFER: begin
                    if (data_valid_i) {pix_b, pix_g, pix_r} = data_i;
                    else              under = 1'b1;
                end
                MODE_BARS: begin
                    pix_r = {CW{~sl.bar[1]}};
                    pix_g = {CW{~sl.bar[2]}};
                    pix_b = {CW{~sl.bar[0]}};
                end
                MODE_SOLID: {pix_r, pix_g, pix_b} = solid;
                MODE_CHECKER: begin
                    pix_r = {CW{sl.chk}};
                    pix_g = {CW{sl.chk}};
                    pix_b = {CW{sl.chk}};
                end
                default: ;
            endcase
        end
    end

    // Registered pin outputs.
    always_ff @(posedge clk) begin
        if (!run) begin
            hsync_o       <= ~hs_pol_i;
            vsync_o       <= ~vs_pol_i;
            de_o          <= 1'b0;
            frame_start_o <= 1'b0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
        end else begin
            hsync_o       <= sl.hs ? hs_pol : ~hs_pol;
            vsync_o       <= sl.vs ? vs_pol : ~vs_pol;
            de_o          <= sl.act;
            frame_start_o <= sl.fs;
            red_o         <= pix_r;
            green_o       <= pix_g;
            blue_o        <= pix_b;
        end
    end

    // Sticky underflow flag; a new underflow wins over a clear.
    always_ff @(posedge clk) begin
        if (!resetn)                 underflow_o <= 1'b0;
        else if (run && under)       underflow_o <= 1'b1;
        else if (underflow_clr_i)    underflow_o <= 1'b0;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen with a frame-index reference model.
module tb_vga_timing_gen;

    localparam int HW = 11;
    localparam int VW = 10;
    localparam int CW = 4;
    localparam int L  = 2;
    localparam int BS = 2;

    logic            clk = 1'b0;
    logic            resetn, en_i;
    logic [HW-1:0]   h_total_i, h_sync_i, h_act_start_i, h_act_end_i;
    logic [VW-1:0]   v_total_i, v_sync_i, v_act_start_i, v_act_end_i;
    logic            hs_pol_i, vs_pol_i;
    logic [1:0]      mode_i;
    logic [3*CW-1:0] solid_i, data_i;
    logic            data_valid_i, underflow_clr_i;
    logic            data_req_o, hsync_o, vsync_o, de_o, frame_start_o, underflow_o;
    logic [CW-1:0]   red_o, green_o, blue_o;

    int errors = 0;
    int checks = 0;

    vga_timing_gen #(.HW(HW), .VW(VW), .CW(CW), .REQ_LAT(L), .BAR_SHIFT(BS)) dut (
        .clk(clk), .resetn(resetn), .en_i(en_i),
        .h_total_i(h_total_i), .h_sync_i(h_sync_i),
        .h_act_start_i(h_act_start_i), .h_act_end_i(h_act_end_i),
        .v_total_i(v_total_i), .v_sync_i(v_sync_i),
        .v_act_start_i(v_act_start_i), .v_act_end_i(v_act_end_i),
        .hs_pol_i(hs_pol_i), .vs_pol_i(vs_pol_i), .mode_i(mode_i),
        .solid_i(solid_i), .data_i(data_i), .data_valid_i(data_valid_i),
        .underflow_clr_i(underflow_clr_i), .data_req_o(data_req_o),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .frame_start_o(frame_start_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit hs, vs, act, fs;
        int mode, hx, vy;
    } desc_t;

    desc_t hist [L+1];
    desc_t empty_d = '{0, 0, 0, 0, 0, 0, 0};
    int t = 0;
    int sh_ht, sh_hs, sh_has, sh_hae, sh_vt, sh_vs, sh_vas, sh_vae, sh_mode, sh_solid;
    bit sh_hp, sh_vp;
    int e_hs, e_vs, e_de, e_fs, e_rgb, e_req, e_uf = 0;

    function automatic bit in_act(input int h, input int v);
        return (h >= sh_has) && (h < sh_hae) && (v >= sh_vas) && (v < sh_vae);
    endfunction

    function automatic int colour(input desc_t e, input bit valid, input int din);
        int b;
        case (e.mode)
            0: return valid ? (((din & 15) << 8) | (din & 'hF0) | ((din >> 8) & 15)) : 0;
            1: begin
                b = (e.hx >> BS) % 8;
                return ((((b / 2) % 2) != 0) ? 0 : 'hF00) |
                       ((((b / 4) % 2) != 0) ? 0 : 'h0F0) |
                       (((b % 2) != 0) ? 0 : 'h00F);
            end
            2: return sh_solid;
            default: return ((((e.hx >> BS) ^ (e.vy >> BS)) & 1) != 0) ? 'hFFF : 0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit run, setuf;
        int H, V, h, v;
        desc_t d, e;
        run = resetn && en_i;
        H = (sh_ht < 1) ? 1 : sh_ht;
        V = (sh_vt < 1) ? 1 : sh_vt;
        h = t % H;
        v = t / H;
        d = empty_d;
        if (run) begin
            d.hs = h < sh_hs;
            d.vs = v < sh_vs;
            d.act = in_act(h, v);
            d.fs = (t == 0);
            d.mode = sh_mode;
            d.hx = (h - sh_has) & ((1 << HW) - 1);
            d.vy = (v - sh_vas) & ((1 << VW) - 1);
        end
        for (int i = L; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        if (!run) for (int i = 0; i <= L; i++) hist[i] = empty_d;
        e = hist[L];
        setuf = run && e.act && (e.mode == 0) && !data_valid_i;
        if (!run) begin
            e_hs = !hs_pol_i; e_vs = !vs_pol_i; e_de = 0; e_fs = 0; e_rgb = 0;
        end else begin
            e_hs = e.hs ? sh_hp : !sh_hp;
            e_vs = e.vs ? sh_vp : !sh_vp;
            e_de = e.act;
            e_fs = e.fs;
            e_rgb = e.act ? colour(e, data_valid_i, int'(data_i)) : 0;
        end
        if (!resetn)              e_uf = 0;
        else if (setuf)           e_uf = 1;
        else if (underflow_clr_i) e_uf = 0;
        if (!run || t == H * V - 1) begin
            t = 0;
            sh_ht = int'(h_total_i); sh_hs = int'(h_sync_i);
            sh_has = int'(h_act_start_i); sh_hae = int'(h_act_end_i);
            sh_vt = int'(v_total_i); sh_vs = int'(v_sync_i);
            sh_vas = int'(v_act_start_i); sh_vae = int'(v_act_end_i);
            sh_hp = hs_pol_i; sh_vp = vs_pol_i;
            sh_mode = int'(mode_i); sh_solid = int'(solid_i);
        end else begin
            t++;
        end
        H = (sh_ht < 1) ? 1 : sh_ht;
        e_req = (run && in_act(t % H, t / H) && sh_mode == 0) ? 1 : 0;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: compare outputs against the model, then drive per-cycle data inputs.
    task automatic step(input bit valid, input bit clr);
        @(negedge clk);
        check("hsync", hsync_o, e_hs);
        check("vsync", vsync_o, e_vs);
        check("de", de_o, e_de);
        check("frame_start", frame_start_o, e_fs);
        check("rgb", {red_o, green_o, blue_o}, e_rgb);
        check("data_req", data_req_o, e_req);
        check("underflow", underflow_o, e_uf);
        data_i = 12'($urandom);
        data_valid_i = valid;
        underflow_clr_i = clr;
    endtask

    task automatic measure(output int n, output int de_n, output int hl_n, output int vh_n);
        n = 0; de_n = 0; hl_n = 0; vh_n = 0;
        do begin
            step(1'b1, 1'b0);
            n++;
            de_n += int'(de_o);
            hl_n += int'(!hsync_o);
            vh_n += int'(vsync_o);
        end while (!frame_start_o && n < 2000);
        if (!frame_start_o) check("fs_timeout", frame_start_o, 1);
    endtask

    task automatic wait_req();
        int k = 0;
        while (!data_req_o && k < 2000) begin
            step(1'b1, 1'b0);
            k++;
        end
        if (!data_req_o) check("req_timeout", data_req_o, 1);
    endtask

    task automatic rand_timing();
        h_total_i     = HW'($urandom_range(1, 40));
        h_sync_i      = HW'($urandom_range(0, 32'(h_total_i)));
        h_act_start_i = HW'($urandom_range(0, 32'(h_total_i)));
        h_act_end_i   = HW'($urandom_range(32'(h_act_start_i), 32'(h_total_i) + 1));
        v_total_i     = VW'($urandom_range(1, 10));
        v_sync_i      = VW'($urandom_range(0, 32'(v_total_i)));
        v_act_start_i = VW'($urandom_range(0, 32'(v_total_i)));
        v_act_end_i   = VW'($urandom_range(32'(v_act_start_i), 32'(v_total_i) + 1));
        hs_pol_i      = 1'($urandom);
        vs_pol_i      = 1'($urandom);
        mode_i        = 2'($urandom);
        solid_i       = 12'($urandom);
    endtask

    initial begin
        int n, de_n, hl_n, vh_n, idle_cnt, r;
        resetn = 1'b0; en_i = 1'b0;
        h_total_i = 20; h_sync_i = 3; h_act_start_i = 5; h_act_end_i = 17;
        v_total_i = 8;  v_sync_i = 1; v_act_start_i = 2; v_act_end_i = 6;
        hs_pol_i = 1'b0; vs_pol_i = 1'b1; mode_i = 2'd0; solid_i = 12'h5A3;
        data_i = '0; data_valid_i = 1'b1; underflow_clr_i = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        check("rst_de", de_o, 0);
        check("rst_hsync", hsync_o, 1);
        check("rst_vsync", vsync_o, 0);
        check("rst_uf", underflow_o, 0);
        resetn = 1'b1;
        step(1'b1, 1'b0);
        en_i = 1'b1;

        // Scaled-down fixed timing: first pulse latency, frame period, de/sync counts.
        measure(n, de_n, hl_n, vh_n);
        check("first_fs_lat", n, L + 1);
        measure(n, de_n, hl_n, vh_n);
        check("frame_period", n, 160);
        check("de_per_frame", de_n, 48);
        check("hsync_low", hl_n, 24);
        check("vsync_high", vh_n, 20);

        // Mid-frame h_total change applies only from the next frame.
        repeat (30) step(1'b1, 1'b0);
        h_total_i = 24;
        measure(n, de_n, hl_n, vh_n);
        check("shadow_cur_frame", n + 30, 160);
        measure(n, de_n, hl_n, vh_n);
        check("shadow_next_frame", n, 192);
        h_total_i = 20;

        // Underflow: drop, hold, clear-with-drop, clear alone.
        wait_req();
        repeat (L - 1) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (L + 2) step(1'b1, 1'b0);
        check("uf_set", underflow_o, 1);
        wait_req();
        repeat (L - 1) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check("uf_clr_and_set", underflow_o, 1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("uf_clr", underflow_o, 0);

        // Colour bars, then reset mid-line and an idle period.
        mode_i = 2'd1;
        measure(n, de_n, hl_n, vh_n);
        measure(n, de_n, hl_n, vh_n);
        repeat (47) step(1'b1, 1'b0);
        resetn = 1'b0;
        step(1'b1, 1'b0);
        check("rst_mid_de", de_o, 0);
        check("rst_mid_hsync", hsync_o, 1);
        resetn = 1'b1;
        en_i = 1'b0;
        repeat (5) step(1'b1, 1'b0);
        en_i = 1'b1;
        measure(n, de_n, hl_n, vh_n);
        check("restart_fs_lat", n, L + 1);

        // Randomized traffic with mid-frame changes, idle gaps and resets.
        idle_cnt = 0;
        for (int i = 0; i < 15000; i++) begin
            step($urandom_range(0, 15) != 0, $urandom_range(0, 63) == 0);
            if (!resetn) resetn = 1'b1;
            r = int'($urandom_range(0, 999));
            if (idle_cnt > 0) begin
                idle_cnt--;
                if (idle_cnt == 0) en_i = 1'b1;
            end else if (r < 12) begin
                rand_timing();
            end else if (r < 15) begin
                mode_i = 2'($urandom);
            end else if (r < 18) begin
                en_i = 1'b0;
                idle_cnt = int'($urandom_range(1, 6));
            end else if (r == 18) begin
                resetn = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
